// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the multicycle MULT/DIV engine: FSM state encoding
// and the op select encoding that also drives the HI/LO source muxes.
package muldiv_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_FIXUP,
    S_DONE
  } state_e;

  localparam logic OP_DIV  = 1'b0;
  localparam logic OP_MULT = 1'b1;

endpackage

// File: rtl/muldiv_sequencer_step.sv
// muldiv_step: one combinational iteration of the engine.
//   MULT: radix-2 Booth add/sub followed by arithmetic shift right of {acc, mplr, q-1}.
//   DIV : restoring step, shift {rem, dividend} left and trial-subtract the divisor.
module muldiv_step
  import muldiv_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             op,
  input  logic [WIDTH:0]   acc_i,
  input  logic [WIDTH-1:0] mplr_i,
  input  logic             qm1_i,
  input  logic [WIDTH:0]   mcand_i,
  output logic [WIDTH:0]   acc_o,
  output logic [WIDTH-1:0] mplr_o,
  output logic             qm1_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shl;
  logic [WIDTH:0] diff;

  // Single Booth or restoring iteration, selected by op
  always_comb begin
    sum    = acc_i;
    shl    = {acc_i[WIDTH-1:0], mplr_i[WIDTH-1]};
    diff   = shl - mcand_i;
    acc_o  = acc_i;
    mplr_o = mplr_i;
    qm1_o  = qm1_i;
    if (op == OP_MULT) begin
      case ({mplr_i[0], qm1_i})
        2'b01:   sum = acc_i + mcand_i;
        2'b10:   sum = acc_i - mcand_i;
        default: sum = acc_i;
      endcase
      acc_o  = {sum[WIDTH], sum[WIDTH:1]};
      mplr_o = {sum[0], mplr_i[WIDTH-1:1]};
      qm1_o  = mplr_i[0];
    end else begin
      // Negative trial result means the divisor did not fit: keep the shifted remainder
      acc_o  = diff[WIDTH] ? shl : diff;
      mplr_o = {mplr_i[WIDTH-2:0], ~diff[WIDTH]};
      qm1_o  = 1'b0;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multicycle signed MULT/DIV engine with its sequencing FSM,
// feeding HI/LO of the multicycle core. One iteration per clock, WIDTH iterations.
// Optional macro MULDIV_DIV0_TRAP_EN: adds div_zero port; DIV by zero skips to DONE
// without writing HI/LO.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             hilo_write,
  output logic             hilo_src,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
`ifdef MULDIV_DIV0_TRAP_EN
  ,
  output logic             div_zero
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic             qm1_q, qm1_d;
  logic [WIDTH:0]   mcand_q, mcand_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             src_q, src_d;
  logic             done_q, done_d;
  logic             hw_q, hw_d;
`ifdef MULDIV_DIV0_TRAP_EN
  logic             dz_q, dz_d;
`endif

  logic [WIDTH:0]   step_acc;
  logic [WIDTH-1:0] step_mplr;
  logic             step_qm1;
  logic [WIDTH-1:0] a_abs, b_abs, rem, rem_fix, quo_fix;
  logic             q_neg;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op      (op_q),
    .acc_i   (acc_q),
    .mplr_i  (mplr_q),
    .qm1_i   (qm1_q),
    .mcand_i (mcand_q),
    .acc_o   (step_acc),
    .mplr_o  (step_mplr),
    .qm1_o   (step_qm1)
  );

  // Next-state, datapath loading and result fixup
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mplr_d  = mplr_q;
    qm1_d   = qm1_q;
    mcand_d = mcand_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    src_d   = src_q;
    done_d  = 1'b0;
    hw_d    = 1'b0;
`ifdef MULDIV_DIV0_TRAP_EN
    dz_d    = 1'b0;
`endif
    a_abs   = a_q[WIDTH-1] ? -a_q : a_q;
    b_abs   = b_q[WIDTH-1] ? -b_q : b_q;
    rem     = acc_q[WIDTH-1:0];
    rem_fix = a_q[WIDTH-1] ? -rem : rem;
    // Zero divisor leaves the all-ones quotient un-negated
    q_neg   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) && (b_q != '0);
    quo_fix = q_neg ? -mplr_q : mplr_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = a_in;
          b_d     = b_in;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        acc_d   = '0;
        qm1_d   = 1'b0;
        cnt_d   = CW'(WIDTH - 1);
        state_d = S_RUN;
        if (op_q == OP_MULT) begin
          mplr_d  = b_q;
          mcand_d = {a_q[WIDTH-1], a_q};
        end else begin
          mplr_d  = a_abs;
          mcand_d = {1'b0, b_abs};
        end
`ifdef MULDIV_DIV0_TRAP_EN
        if (op_q == OP_DIV && b_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          dz_d    = 1'b1;
          src_d   = op_q;
        end
`endif
      end
      S_RUN: begin
        acc_d  = step_acc;
        mplr_d = step_mplr;
        qm1_d  = step_qm1;
        if (cnt_q == '0) begin
          state_d = S_FIXUP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FIXUP: begin
        if (op_q == OP_MULT) begin
          hi_d = acc_q[WIDTH-1:0];
          lo_d = mplr_q;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        src_d   = op_q;
        done_d  = 1'b1;
        hw_d    = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
      qm1_q   <= 1'b0;
      mcand_q <= '0;
      op_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      src_q   <= 1'b0;
      done_q  <= 1'b0;
      hw_q    <= 1'b0;
`ifdef MULDIV_DIV0_TRAP_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mplr_q  <= mplr_d;
      qm1_q   <= qm1_d;
      mcand_q <= mcand_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      src_q   <= src_d;
      done_q  <= done_d;
      hw_q    <= hw_d;
`ifdef MULDIV_DIV0_TRAP_EN
      dz_q    <= dz_d;
`endif
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign hilo_write = hw_q;
  assign hilo_src   = src_q;
  assign hi_out     = hi_q;
  assign lo_out     = lo_q;
`ifdef MULDIV_DIV0_TRAP_EN
  assign div_zero   = dz_q;
`endif

endmodule
